// File: rtl/williams2_video_out.sv
// williams2_video_out
// Video output stage between the williams2 core and the MiSTer VGA outputs.
// Takes one 4-bit R/G/B/intensity pixel plus raw syncs per ce_pix, derives
// blanking from sync-relative pixel/line counters, expands colour to 8 bits
// per channel and tracks whether the line length is stable.
//
// Optional feature macro: WILLIAMS2_VIDEO_INTENSITY_EN
//   defined   : colour = c * (i_in + 1)   (0..240)
//   undefined : colour = {c, c}           (0..255), i_in ignored
//
// Ports
//   clk_sys               single clock, rising edge
//   reset                 asynchronous, active-high
//   ce_pix                pixel enable (single-cycle pulse)
//   r_in/g_in/b_in/i_in   4-bit colour and intensity
//   hs_in/vs_in           raw syncs, polarity set by SYNC_ACTIVE_LOW
//   VGA_R/VGA_G/VGA_B     8-bit colour, 0 while blanked
//   VGA_HS/VGA_VS         delay-matched syncs, same polarity as inputs
//   VGA_DE                ~(hblank | vblank)
//   hblank/vblank         derived blanking
//   frame_start           one clk_sys pulse on the stage-2 update of a vs edge
//   locked                line length stable
//   lock_state            lock FSM state (debug)
//
// Flow control: there is no back-pressure. A pixel is transferred exactly on
// clk_sys cycles with ce_pix=1; on all other cycles every register holds.
module williams2_video_out #(
  parameter int unsigned H_START         = 56,
  parameter int unsigned H_LEN           = 292,
  parameter int unsigned V_START         = 8,
  parameter int unsigned V_LEN           = 240,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  input  logic [3:0] i_in,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_DE,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start,
  output logic       locked,
  output logic [1:0] lock_state
);

  localparam logic SYNC_ACT  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  localparam logic [9:0] H_FIRST = 10'(H_START);
  localparam logic [9:0] H_END   = 10'(H_START + H_LEN);
  localparam logic [9:0] V_FIRST = 10'(V_START);
  localparam logic [9:0] V_END   = 10'(V_START + V_LEN);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Stage 1 registers
  logic [3:0]  s1_r, s1_g, s1_b;
  logic        s1_hs, s1_vs, s1_vs_edge;
  logic [8:0]  hcnt, vcnt, prev_len;
  logic        seen_vs;
  lock_state_t state_q, state_d;
  logic        capture;

  // Leading edge = transition into the active level, against the last sample.
  logic hs_edge, vs_edge;
  assign hs_edge = (hs_in == SYNC_ACT) && (s1_hs != SYNC_ACT);
  assign vs_edge = (vs_in == SYNC_ACT) && (s1_vs != SYNC_ACT);

`ifdef WILLIAMS2_VIDEO_INTENSITY_EN
  logic [3:0] s1_i;

  function automatic logic [7:0] shade(input logic [3:0] c, input logic [3:0] i);
    return 8'(c) * (8'(i) + 8'd1);
  endfunction
`else
  logic unused_i;
  assign unused_i = ^i_in;

  function automatic logic [7:0] shade(input logic [3:0] c);
    return {c, c};
  endfunction
`endif

  // Lock FSM: compares consecutive line lengths at each hs leading edge.
  // A saturated pixel counter means hs has gone missing, which always
  // drops lock regardless of any simultaneous edge.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (ce_pix) begin
      if (hcnt == 9'h1FF) begin
        state_d = UNLOCKED;
      end else if (hs_edge) begin
        case (state_q)
          UNLOCKED: begin
            capture = 1'b1;
            state_d = CHECK;
          end
          CHECK: begin
            if (hcnt == prev_len) state_d = LOCKED;
            else                  capture = 1'b1;
          end
          LOCKED: begin
            if (hcnt != prev_len) begin
              capture = 1'b1;
              state_d = CHECK;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_r       <= '0;
      s1_g       <= '0;
      s1_b       <= '0;
`ifdef WILLIAMS2_VIDEO_INTENSITY_EN
      s1_i       <= '0;
`endif
      s1_hs      <= SYNC_IDLE;
      s1_vs      <= SYNC_IDLE;
      s1_vs_edge <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      prev_len   <= '0;
      seen_vs    <= 1'b0;
      state_q    <= UNLOCKED;
    end else if (ce_pix) begin
      s1_r       <= r_in;
      s1_g       <= g_in;
      s1_b       <= b_in;
`ifdef WILLIAMS2_VIDEO_INTENSITY_EN
      s1_i       <= i_in;
`endif
      s1_hs      <= hs_in;
      s1_vs      <= vs_in;
      s1_vs_edge <= vs_edge;
      state_q    <= state_d;
      if (capture) prev_len <= hcnt;
      if (vs_edge) seen_vs <= 1'b1;

      if (hs_edge)               hcnt <= '0;
      else if (hcnt != 9'h1FF)   hcnt <= hcnt + 9'd1;

      // vs wins over a coincident hs edge
      if (vs_edge)                        vcnt <= '0;
      else if (hs_edge && vcnt != 9'h1FF) vcnt <= vcnt + 9'd1;
    end
  end

  // Stage 2: blanking, gated colour and syncs, all from the same stage-1 sample.
  logic h_act, v_act, de_next;
  logic [7:0] r_x, g_x, b_x;
  assign h_act   = ({1'b0, hcnt} >= H_FIRST) && ({1'b0, hcnt} < H_END);
  assign v_act   = ({1'b0, vcnt} >= V_FIRST) && ({1'b0, vcnt} < V_END) && seen_vs;
  assign de_next = h_act && v_act;
`ifdef WILLIAMS2_VIDEO_INTENSITY_EN
  assign r_x = shade(s1_r, s1_i);
  assign g_x = shade(s1_g, s1_i);
  assign b_x = shade(s1_b, s1_i);
`else
  assign r_x = shade(s1_r);
  assign g_x = shade(s1_g);
  assign b_x = shade(s1_b);
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= SYNC_IDLE;
      VGA_VS      <= SYNC_IDLE;
      VGA_DE      <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      // Cleared on every non-enable cycle so the pulse is one clk_sys wide.
      frame_start <= ce_pix & s1_vs_edge;
      if (ce_pix) begin
        VGA_R  <= de_next ? r_x : 8'd0;
        VGA_G  <= de_next ? g_x : 8'd0;
        VGA_B  <= de_next ? b_x : 8'd0;
        VGA_HS <= s1_hs;
        VGA_VS <= s1_vs;
        VGA_DE <= de_next;
        hblank <= ~h_act;
        vblank <= ~v_act;
      end
    end
  end

  assign locked     = (state_q == LOCKED);
  assign lock_state = state_q;

endmodule

// File: tb/tb_williams2_video_out.sv
// Testbench for williams2_video_out.
module tb_williams2_video_out;

  localparam logic ACT  = 1'b0;
  localparam logic IDLE = 1'b1;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic [3:0] r_in, g_in, b_in, i_in;
  logic       hs_in, vs_in;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_DE, hblank, vblank, frame_start, locked;
  logic [1:0] lock_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  williams2_video_out dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .i_in        (i_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_DE      (VGA_DE),
    .hblank      (hblank),
    .vblank      (vblank),
    .frame_start (frame_start),
    .locked      (locked),
    .lock_state  (lock_state)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] r, g, b;
    logic de, hb, vb, hs, vs, fs;
  } vout_t;

  localparam vout_t RST_OUT = '{r: 8'd0, g: 8'd0, b: 8'd0, de: 1'b0, hb: 1'b1,
                                vb: 1'b1, hs: IDLE, vs: IDLE, fs: 1'b0};

  vout_t shown;   // expectation for what the outputs show now
  vout_t pend;    // expectation for the most recent sample (shows after next ce)
  int    m_h, m_v, m_ref;
  bit    m_seen, m_have_ref, m_locked;
  logic  m_prev_hs, m_prev_vs;
  int    de_seen, fs_seen;

  function automatic logic [7:0] colour(input logic [3:0] c, input logic [3:0] i);
`ifdef WILLIAMS2_VIDEO_INTENSITY_EN
    return 8'(int'(c) * (int'(i) + 1));
`else
    return (i > 4'd15) ? 8'd0 : 8'(int'(c) * 17);
`endif
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_ref = 0;
    m_seen = 0; m_have_ref = 0; m_locked = 0;
    m_prev_hs = IDLE; m_prev_vs = IDLE;
    shown = RST_OUT; pend = RST_OUT;
  endtask

  task automatic model_step(input logic hs, input logic vs,
                            input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b, input logic [3:0] i,
                            output vout_t o);
    bit hl, vl;
    hl = (hs == ACT) && (m_prev_hs != ACT);
    vl = (vs == ACT) && (m_prev_vs != ACT);
    m_prev_hs = hs;
    m_prev_vs = vs;
    // line-length tracking uses the count reached before this sample
    if (m_h == 511) begin
      m_have_ref = 0; m_locked = 0;
    end else if (hl) begin
      if (!m_have_ref) begin m_ref = m_h; m_have_ref = 1; end
      else if (m_h == m_ref) m_locked = 1;
      else begin m_ref = m_h; m_locked = 0; end
    end
    if (hl) m_h = 0; else if (m_h < 511) m_h = m_h + 1;
    if (vl) begin m_v = 0; m_seen = 1; end
    else if (hl && m_v < 511) m_v = m_v + 1;
    o.hb = !(m_h >= 56 && m_h < 56 + 292);
    o.vb = !(m_v >= 8 && m_v < 8 + 240) || !m_seen;
    o.de = !o.hb && !o.vb;
    o.r  = o.de ? colour(r, i) : 8'd0;
    o.g  = o.de ? colour(g, i) : 8'd0;
    o.b  = o.de ? colour(b, i) : 8'd0;
    o.hs = hs;
    o.vs = vs;
    o.fs = vl;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    check("vga_r",  32'(VGA_R),       32'(shown.r));
    check("vga_g",  32'(VGA_G),       32'(shown.g));
    check("vga_b",  32'(VGA_B),       32'(shown.b));
    check("vga_de", 32'(VGA_DE),      32'(shown.de));
    check("hblank", 32'(hblank),      32'(shown.hb));
    check("vblank", 32'(vblank),      32'(shown.vb));
    check("vga_hs", 32'(VGA_HS),      32'(shown.hs));
    check("vga_vs", 32'(VGA_VS),      32'(shown.vs));
    check("fstart", 32'(frame_start), 32'(shown.fs));
  endtask

  // ---------------- drivers ----------------
  task automatic pix(input logic hs, input logic vs, input logic [3:0] r,
                     input logic [3:0] g, input logic [3:0] b, input logic [3:0] i);
    vout_t nxt;
    int    idle;
    hs_in = hs; vs_in = vs; r_in = r; g_in = g; b_in = b; i_in = i;
    ce_pix = 1'b1;
    @(posedge clk_sys); #1;
    ce_pix = 1'b0;
    model_step(hs, vs, r, g, b, i, nxt);
    shown = pend;
    pend  = nxt;
    check_outs();
    check("locked", 32'(locked), 32'(m_locked));
    if (VGA_DE) de_seen++;
    if (frame_start) fs_seen++;
    idle = $urandom_range(1, 2);
    repeat (idle) begin
      @(posedge clk_sys); #1;
      check("fs_width", 32'(frame_start), 32'd0);
      check("de_hold",  32'(VGA_DE),      32'(shown.de));
      check("r_hold",   32'(VGA_R),       32'(shown.r));
    end
  endtask

  // mode 0: all 15; mode 1: random; mode 2: r=15 with intensity sweep
  task automatic line(input int len, input bit vs_on, input int mode);
    for (int p = 0; p < len; p++) begin
      logic [3:0] r, g, b, i;
      r = 4'($urandom_range(0, 15));
      g = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      i = 4'($urandom_range(0, 15));
      if (mode == 0) begin r = 4'd15; g = 4'd15; b = 4'd15; i = 4'd15; end
      if (mode == 2) begin r = 4'd15; i = 4'(p); end
      pix((p < 4) ? ACT : IDLE, vs_on ? ACT : IDLE, r, g, b, i);
    end
  endtask

  // 260 lines; only lines around the vertical active boundaries are full width
  task automatic frame(input int mode);
    for (int ln = 0; ln < 260; ln++) begin
      bit full;
      full = (ln >= 6 && ln <= 10) || (ln >= 245 && ln <= 249);
      line(full ? 384 : 12, ln < 3, mode);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ce_pix = 1'b0; hs_in = IDLE; vs_in = IDLE;
    r_in = '0; g_in = '0; b_in = '0; i_in = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    check("locked_rst", 32'(locked), 32'd0);
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    // nominal frame, full-scale colour
    de_seen = 0; fs_seen = 0;
    frame(0);
    check("de_count_f1", 32'(de_seen), 32'd1752);
    check("fs_count_f1", 32'(fs_seen), 32'd1);

    // ce_pix held low: everything holds
    repeat (20) @(posedge clk_sys);
    #1;
    check_outs();
    check("locked_hold", 32'(locked), 32'(m_locked));

    // intensity sweep frame
    de_seen = 0; fs_seen = 0;
    frame(2);
    check("de_count_f2", 32'(de_seen), 32'd1752);
    check("fs_count_f2", 32'(fs_seen), 32'd1);

    // lock: three equal lines, a short one, then recovery
    line(384, 1'b0, 1); line(384, 1'b0, 1); line(384, 1'b0, 1);
    check("lock_rise", 32'(locked), 32'd1);
    line(380, 1'b0, 1);
    line(384, 1'b0, 1);
    check("lock_drop", 32'(locked), 32'd0);
    line(384, 1'b0, 1);
    check("lock_wait", 32'(locked), 32'd0);
    line(384, 1'b0, 1);
    check("lock_again", 32'(locked), 32'd1);

    // hs missing for 600 pixels
    for (int p = 0; p < 600; p++)
      pix(IDLE, IDLE, 4'($urandom_range(0, 15)), 4'd3, 4'd9, 4'($urandom_range(0, 15)));
    check("nohs_locked", 32'(locked), 32'd0);
    check("nohs_hblank", 32'(hblank), 32'd1);
    line(384, 1'b0, 1);

    // reach an active line, then reset in the middle of it
    line(12, 1'b1, 1);
    for (int ln = 1; ln < 9; ln++) line(12, 1'b0, 1);
    for (int p = 0; p < 100; p++)
      pix((p < 4) ? ACT : IDLE, IDLE, 4'd15, 4'd15, 4'd15, 4'd15);
    check("pre_rst_de", 32'(VGA_DE), 32'd1);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    check("locked_mid_rst", 32'(locked), 32'd0);
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;

    // no vs yet: stays blanked though vcnt crosses the active range
    de_seen = 0;
    for (int ln = 0; ln < 12; ln++) line(384, 1'b0, 1);
    check("no_vs_de", 32'(de_seen), 32'd0);

    // vs returns: line 8 of the new frame is active
    line(12, 1'b1, 1);
    for (int ln = 1; ln < 8; ln++) line(12, 1'b0, 1);
    de_seen = 0;
    line(384, 1'b0, 1);
    line(12, 1'b0, 1);
    check("post_vs_de", 32'(de_seen), 32'd292);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
